// File: rtl/dma_engineer.sv
// Weight-fetch DMA responder: accepts one start/length request, issues one read per cycle
// to a fixed-latency memory, and streams words out. Optional macro: DMA_ENGINEER_BOUNDS_CHECK_EN.
module dma_engineer #(
  parameter int unsigned DW        = 512,
  parameter int unsigned AW        = 27,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_engineer_req,
  input  logic [AW-1:0] dma_engineer_start_addr,
  input  logic [AW-1:0] dma_engineer_length,
  output logic          dma_engineer_ack,
  output logic [DW-1:0] dma_engineer_dout,
  output logic          dma_engineer_dout_en,
  output logic          dma_engineer_dout_eop,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        rem_q, rem_d;
  logic                 ack_q, busy_q, rd_en_q, rd_en_d;
  logic                 issue_c, last_c;
  logic [MEM_LAT-1:0]   vld_q, vld_d, last_q, last_d, vld_sh_c;

  // Drain completes once this cycle's shift leaves the valid pipe empty.
  assign vld_sh_c = vld_q << 1;

  always_comb begin : fsm_next
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma_engineer_req) begin
          addr_d  = dma_engineer_start_addr;
          rem_d   = dma_engineer_length;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = (rem_q == '0) ? ST_IDLE : ST_READ;
      ST_READ: begin
        issue_c = 1'b1;
        last_c  = (rem_q == AW'(1));
        addr_d  = addr_q + AW'(1);
        rem_d   = rem_q - AW'(1);
        if (last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_sh_c == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : pipe_next
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = issue_c;
    last_d[0] = last_c;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

`ifdef DMA_ENGINEER_BOUNDS_CHECK_EN
  localparam logic [AW-1:0] MEM_LIM = AW'(MEM_WORDS);

  logic               oob_c, err_q;
  logic [MEM_LAT-1:0] zero_q, zero_d;

  // Out-of-range words are never read; their beat is flagged to output zero.
  assign rd_en_d = (state_d == ST_READ) && (addr_d < MEM_LIM);
  assign oob_c   = issue_c && (addr_q >= MEM_LIM);

  always_comb begin : zero_next
    zero_d    = '0;
    zero_d[0] = oob_c;
    for (int i = 1; i < int'(MEM_LAT); i++) zero_d[i] = zero_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= '0;
      err_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      err_q  <= err_q | oob_c;
    end
  end

  assign dma_engineer_dout = zero_q[MEM_LAT-1] ? '0 : mem_rd_data;
  assign err               = err_q;
`else
  logic unused_c;

  assign rd_en_d           = (state_d == ST_READ);
  assign dma_engineer_dout = mem_rd_data;
  assign err               = 1'b0;
  assign unused_c          = ^MEM_WORDS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      vld_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ack_q   <= (state_d == ST_ACK);
      busy_q  <= (state_d != ST_IDLE);
      rd_en_q <= rd_en_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign dma_engineer_ack      = ack_q;
  assign busy                  = busy_q;
  assign mem_rd_en             = rd_en_q;
  assign mem_rd_addr           = addr_q;
  assign dma_engineer_dout_en  = vld_q[MEM_LAT-1];
  assign dma_engineer_dout_eop = last_q[MEM_LAT-1];

endmodule

// File: tb/tb_dma_engineer.sv
// Directed bench for dma_engineer with a two-cycle-latency weight memory model.
module tb_dma_engineer;

  localparam int unsigned DW        = 512;
  localparam int unsigned AW        = 27;
  localparam int unsigned MEM_LAT   = 2;
  localparam int unsigned MEM_WORDS = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [AW-1:0] start = '0;
  logic [AW-1:0] len = '0;
  logic          ack, en, eop, rd_en, busy, err;
  logic [DW-1:0] dout, rd_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] p1 = '0, p2 = '0;

  int checks = 0;
  int errors = 0;
  int n_en = 0, n_eop = 0, n_rd = 0;

  dma_engineer #(.DW(DW), .AW(AW), .MEM_LAT(MEM_LAT), .MEM_WORDS(MEM_WORDS)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .dma_engineer_req        (req),
    .dma_engineer_start_addr (start),
    .dma_engineer_length     (len),
    .dma_engineer_ack        (ack),
    .dma_engineer_dout       (dout),
    .dma_engineer_dout_en    (en),
    .dma_engineer_dout_eop   (eop),
    .mem_rd_en               (rd_en),
    .mem_rd_addr             (rd_addr),
    .mem_rd_data             (rd_data),
    .busy                    (busy),
    .err                     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return {16{32'h5A00_0000 ^ 32'(a)}};
  endfunction

  function automatic logic inr(input logic [AW-1:0] a);
`ifdef DMA_ENGINEER_BOUNDS_CHECK_EN
    return (32'(a) < MEM_WORDS);
`else
    return (a == a);
`endif
  endfunction

  function automatic logic [DW-1:0] expv(input logic [AW-1:0] a);
    return inr(a) ? f(a) : '0;
  endfunction

  // Memory model: data only for real strobes, junk otherwise.
  always @(posedge clk) begin
    p1 <= rd_en ? f(rd_addr) : {16{32'hDEAD_BEEF}};
    p2 <= p1;
    if (en)    n_en  <= n_en + 1;
    if (eop)   n_eop <= n_eop + 1;
    if (rd_en) n_rd  <= n_rd + 1;
  end
  assign rd_data = p2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [AW-1:0] s, input logic [AW-1:0] n);
    req = 1'b1; start = s; len = n;
    step();
    chk("ack", ack, 1); chk("busy", busy, 1);
    req = 1'b0;
    step();
    chk("ack_pulse", ack, 0); chk("rd_en", rd_en, inr(s)); chk("rd_addr", rd_addr, s);
    repeat (MEM_LAT) step();
    for (int k = 0; k < int'(n); k++) begin
      chk("beat_en", en, 1);
      chk("beat_eop", eop, (k == int'(n) - 1));
      chk("beat_data", dout, expv(s + AW'(k)));
      step();
    end
    chk("busy_after", busy, 0); chk("en_after", en, 0);
  endtask

  initial begin
    int a0, a1, e0, e1, na, ne, c_en, c_eop, c_rd;
    // Reset state
    step(); step();
    chk("rst_ack", ack, 0); chk("rst_en", en, 0); chk("rst_eop", eop, 0);
    chk("rst_rd_en", rd_en, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_addr", rd_addr, 0);
    rst = 1'b0;
    step();

    // Single word, then a 32-word burst
    xfer(27'd1764, 27'd1);
    xfer(27'd0, 27'd32);

    // Zero length: ack only
    c_rd = n_rd; c_en = n_en;
    req = 1'b1; start = 27'd77; len = 27'd0;
    step(); chk("len0_ack", ack, 1); req = 1'b0;
    step(); chk("len0_idle", busy, 0); chk("len0_ack_low", ack, 0);
    repeat (4) step();
    chk("len0_no_rd", n_rd - c_rd, 0); chk("len0_no_en", n_en - c_en, 0);

    // Request held across the end of a len=4 transfer
    a0 = -1; a1 = -1; e0 = -1; e1 = -1; na = 0; ne = 0;
    req = 1'b1; start = 27'd100; len = 27'd4;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ack) begin
        if (na == 0) a0 = c; else if (na == 1) a1 = c;
        na++;
        if (na == 2) req = 1'b0;
      end
      if (eop) begin
        if (ne == 0) e0 = c; else if (ne == 1) e1 = c;
        ne++;
      end
    end
    chk("held_ack_count", na, 2); chk("held_ack1", a0, 1); chk("held_eop1", e0, 7);
    chk("held_ack2", a1, 9); chk("held_eop2", e1, 15);

    // Reset during beat 3 of a len=8 transfer
    req = 1'b1; start = 27'd200; len = 27'd8;
    step(); req = 1'b0;
    repeat (5) step();
    chk("mid_beat3_en", en, 1); chk("mid_beat3_data", dout, f(27'd202));
    rst = 1'b1;
    step();
    chk("mid_rst_en", en, 0); chk("mid_rst_eop", eop, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_rd", rd_en, 0);
    rst = 1'b0;
    c_en = n_en; c_eop = n_eop;
    repeat (8) step();
    chk("mid_no_en", n_en - c_en, 0); chk("mid_no_eop", n_eop - c_eop, 0);
    xfer(27'd5, 27'd2);

    // Address wrap past 2^AW-1
    xfer(27'h7FF_FFFF, 27'd2);

`ifdef DMA_ENGINEER_BOUNDS_CHECK_EN
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("bc_err_clear", err, 0);
    xfer(27'd2046, 27'd4);
    chk("bc_err_set", err, 1);
    repeat (5) step();
    chk("bc_err_sticky", err, 1);
    rst = 1'b1; step();
    chk("bc_err_rst", err, 0);
    rst = 1'b0; step();
`else
    chk("err_tied_low", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_engineer.md
# dma_engineer

Responder end of the layer weight-fetch DMA protocol: accepts one request at a time from a layer controller (`dma_engineer_req`/`dma_engineer_ack` with start address and length) and streams the requested 512-bit weight words back on `dma_engineer_dout` with `dma_engineer_dout_en`/`dma_engineer_dout_eop`. It sits between a layer instance such as `ip2_layer` and the on-chip weight memory. It issues one memory read per cycle against a fixed-latency read port and forwards the results with no backpressure.

## Interface
Parameters:
- `DW`, 512, data word width; equals weight memory width.
- `AW`, 27, address and length width, in units of `DW`-bit words.
- `MEM_LAT`, 2, weight memory read latency in cycles, ≥1.
- `MEM_WORDS`, 2048, number of valid memory words; used only under `DMA_ENGINEER_BOUNDS_CHECK_EN`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `dma_engineer_req`  in  1  request level; held by the requester until ack.
- `dma_engineer_start_addr`  in  AW  first word address; sampled with req.
- `dma_engineer_length`  in  AW  word count; sampled with req.
- `dma_engineer_ack`  out  1  one-cycle acceptance pulse.
- `dma_engineer_dout`  out  DW  returned word.
- `dma_engineer_dout_en`  out  1  `dout` valid this cycle.
- `dma_engineer_dout_eop`  out  1  last word of the transfer; coincident with `dout_en`.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rd_addr`  out  AW  memory read address.
- `mem_rd_data`  in  DW  memory data, valid `MEM_LAT` cycles after `mem_rd_en`.
- `busy`  out  1  high in every state other than IDLE.
- `err`  out  1  sticky out-of-range flag; present only with the macro, otherwise tied to 0.

## Operation
- FSM states: IDLE, ACK, READ, DRAIN.
- IDLE: when `req`=1, latch `start_addr`/`length` and go to ACK.
- ACK: `ack`=1 for exactly this one cycle.
  - If the latched length is 0, return to IDLE. No beats and no eop are produced.
  - Otherwise go to READ with the address counter set to start and the remaining counter set to length.
- READ: each cycle asserts `mem_rd_en` with `mem_rd_addr` = counter, then increments the address and decrements remaining.
  - The issue carrying remaining==1 is tagged last. The FSM then goes to DRAIN.
- DRAIN: wait until the `MEM_LAT`-deep valid/last shift registers are empty, then go to IDLE.
- Output path:
  - `dout_en` = rd_en delayed `MEM_LAT` cycles.
  - `dout_eop` = last tag delayed `MEM_LAT` cycles.
  - `dout` = `mem_rd_data` passed combinationally.
  - `dout`, `dout_en` and `dout_eop` are all aligned to the same cycle.
- Address arithmetic: modulo 2^AW; wrap past 2^AW−1 goes to 0 silently.
- `req` is ignored outside IDLE. A req held through ACK is not re-accepted; the requester must drop it after ack. A req still high when the FSM returns to IDLE starts a new transfer.

## Timing
- Reset values:
  - `ack`, `dout_en`, `dout_eop`, `mem_rd_en`, `busy`, `err` = 0.
  - `mem_rd_addr` = 0; FSM = IDLE; shift registers cleared.
  - `dout` is not reset; its value is a don't-care while `dout_en`=0.
- Cycle numbering, with req sampled in cycle T (IDLE):
  - `ack` is high in cycle T+1.
  - The first `mem_rd_en` is in cycle T+2.
  - The first `dout_en` is in cycle T+2+MEM_LAT.
  - The beats of length N run back-to-back with no gaps. The eop beat is in cycle T+1+MEM_LAT+N.
  - `busy` falls the cycle after the eop beat. The earliest next ack is 2 cycles after the eop beat.
- Reset mid-transfer: everything clears the next edge. In-flight words are discarded and no eop is emitted.

## Configuration
- `DMA_ENGINEER_BOUNDS_CHECK_EN` defined:
  - Each issued address ≥ `MEM_WORDS` is not read: `mem_rd_en` stays 0 for that word.
  - The corresponding output beat still occurs, with `dout` forced to all-zero.
  - `err` is set and held until `rst`.
  - Beat count and eop timing are unchanged.
- Undefined: no address check, `err` is constant 0, and every address is read.

## Test plan
- Reset, then req with start=1764, len=1, MEM_LAT=2 → ack at T+1, rd addr 1764 at T+2, single beat with en=eop=1 at T+4 carrying mem[1764].
- Req with start=0, len=32 → 32 consecutive beats with data mem[0..31]; eop only on beat 32; `busy` is low one cycle later.
- Req with len=0 → one ack pulse, no `mem_rd_en`, no `dout_en`, FSM back in IDLE at T+2.
- Req held high across the end of a len=4 transfer → exactly one ack per transfer; the second transfer's ack comes 2 cycles after the first eop.
- Assert `rst` during beat 3 of a len=8 transfer → no further `dout_en`/`eop`; a next request completes normally.
- With the macro defined, MEM_WORDS=2048: start=2046, len=4 → beats 1–2 carry memory data, beats 3–4 are zero, `err`=1 and stays high until `rst`.
